// File: rtl/net_div_sched.sv
// Round-robin scheduler that shares one fixed-latency divider among N_REQ requesters.
// Zero divisors are answered locally, and a timeout guard bounds the wait for div_end_i.
module net_div_sched #(
    parameter int N_REQ = 4,
    parameter int DW    = 32,
    parameter int TMO   = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_REQ-1:0]    req_valid_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic [N_REQ*DW-1:0] req_a_i,
    input  logic [N_REQ*DW-1:0] req_b_i,
    output logic [N_REQ-1:0]    rsp_valid_o,
    input  logic [N_REQ-1:0]    rsp_ready_i,
    output logic [DW-1:0]       rsp_q_o,
    output logic [DW-1:0]       rsp_r_o,
    output logic                rsp_dz_o,
    output logic                rsp_tmo_o,
    output logic                div_start_o,
    output logic [DW-1:0]       div_a_o,
    output logic [DW-1:0]       div_b_o,
    input  logic                div_ready_i,
    input  logic                div_end_i,
    input  logic [DW-1:0]       div_q_i,
    input  logic [DW-1:0]       div_r_i,
    output logic                busy_o
);
    // state | meaning
    // IDLE  | arbitrate and accept one request
    // ISSUE | div_start_o high, timeout counter cleared
    // WAIT  | waiting for div_end_i or timeout
    // RESP  | response held for the owner until rsp_ready_i[owner]

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [PW-1:0] gnt_id;
    logic          gnt_found;
    logic [CW-1:0] cnt;
    logic [DW-1:0] gnt_a;
    logic [DW-1:0] gnt_b;

    function automatic logic [PW-1:0] wrap_id(input int v);
        return (v >= N_REQ) ? PW'(v - N_REQ) : PW'(v);
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] id);
        logic [N_REQ-1:0] m;
        m     = '0;
        m[id] = 1'b1;
        return m;
    endfunction

    // Scan from farthest to nearest offset so the nearest valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[wrap_id(int'(ptr) + k)]) begin
                gnt_found = 1'b1;
                gnt_id    = wrap_id(int'(ptr) + k);
            end
        end
    end

    assign gnt_a = req_a_i[gnt_id*DW +: DW];
    assign gnt_b = req_b_i[gnt_id*DW +: DW];

    // Gated by rst_ni so no accept pulse is visible while reset is asserted.
    always_comb begin
        req_ready_o = '0;
        if (rst_ni && state == ST_IDLE && div_ready_i && gnt_found) begin
            req_ready_o = onehot(gnt_id);
        end
    end

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            rsp_valid_o <= '0;
            rsp_q_o     <= '0;
            rsp_r_o     <= '0;
            rsp_dz_o    <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            div_start_o <= 1'b0;
            div_a_o     <= '0;
            div_b_o     <= '0;
        end else begin
            div_start_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (div_ready_i && gnt_found) begin
                        owner   <= gnt_id;
                        div_a_o <= gnt_a;
                        div_b_o <= gnt_b;
                        if (gnt_b == '0) begin
                            rsp_q_o     <= '1;
                            rsp_r_o     <= gnt_a;
                            rsp_dz_o    <= 1'b1;
                            rsp_tmo_o   <= 1'b0;
                            rsp_valid_o <= onehot(gnt_id);
                            state       <= ST_RESP;
                        end else begin
                            div_start_o <= 1'b1;
                            state       <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (div_end_i) begin
                        rsp_q_o     <= div_q_i;
                        rsp_r_o     <= div_r_i;
                        rsp_dz_o    <= 1'b0;
                        rsp_tmo_o   <= 1'b0;
                        rsp_valid_o <= onehot(owner);
                        state       <= ST_RESP;
                    end else if (cnt == CW'(TMO - 1)) begin
                        rsp_q_o     <= '0;
                        rsp_r_o     <= '0;
                        rsp_dz_o    <= 1'b0;
                        rsp_tmo_o   <= 1'b1;
                        rsp_valid_o <= onehot(owner);
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[owner]) begin
                        rsp_valid_o <= '0;
                        ptr         <= wrap_id(int'(owner) + 1);
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_net_div_sched.sv
// Bench for net_div_sched: directed scenarios plus random traffic checked against
// a round-robin/division reference and a behavioural fixed-latency divider.
`timescale 1ns/1ps
module tb_net_div_sched;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [DW-1:0]   rsp_q, rsp_r, div_a, div_b;
    logic [DW-1:0]   div_q = '0;
    logic [DW-1:0]   div_r = '0;
    logic            rsp_dz, rsp_tmo, div_start, busy;
    logic            div_ready = 1'b1;
    logic            div_end = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;
    int mptr   = 0;

    int            dm_lat = 8;
    int            dm_cnt = 0;
    bit            dm_silent = 1'b0;
    bit            inject_end = 1'b0;
    logic [DW-1:0] dm_q = '0;
    logic [DW-1:0] dm_r = '0;

    net_div_sched #(.N_REQ(N), .DW(DW), .TMO(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_q_o(rsp_q), .rsp_r_o(rsp_r), .rsp_dz_o(rsp_dz), .rsp_tmo_o(rsp_tmo),
        .div_start_o(div_start), .div_a_o(div_a), .div_b_o(div_b),
        .div_ready_i(div_ready), .div_end_i(div_end),
        .div_q_i(div_q), .div_r_i(div_r), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Divider: result pulse dm_lat cycles after the start cycle; silent mode never answers.
    always @(negedge clk) begin
        div_end = 1'b0;
        if (inject_end) begin
            div_end    = 1'b1;
            div_q      = 32'hDEAD_BEEF;
            div_r      = 32'h0BAD_F00D;
            inject_end = 1'b0;
        end
        if (dm_cnt > 0) begin
            dm_cnt = dm_cnt - 1;
            if (dm_cnt == 0) begin
                div_end = 1'b1;
                div_q   = dm_q;
                div_r   = dm_r;
            end
        end
        if (div_start && !dm_silent) begin
            dm_cnt = dm_lat;
            dm_q   = (div_b != 0) ? div_a / div_b : '1;
            dm_r   = (div_b != 0) ? div_a % div_b : div_a;
        end
    end

    function automatic int rr_pick(input int ptr, input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_grant(input int budget, output logic [N-1:0] gm, output int t, output bit ok);
        ok = 1'b0; gm = '0; t = 0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (req_ready != '0) begin
                ok = 1'b1; gm = req_ready; t = cyc_n;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(input int budget, output int t, output int starts, output int t_start, output bit ok);
        ok = 1'b0; t = 0; starts = 0; t_start = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (div_start) begin starts++; t_start = cyc_n; end
            if (rsp_valid != '0) begin ok = 1'b1; t = cyc_n; return; end
        end
    endtask

    task automatic handshake(input logic [N-1:0] m);
        rsp_ready = m;
        @(posedge clk); #1;
        rsp_ready = '0;
    endtask

    task automatic apply_reset();
        req_valid = '0; rsp_ready = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        mptr = 0;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h55 + i, 32'h3);
        #2 rst_ni = 1'b0;
        repeat (2) @(negedge clk); #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if ({rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo, div_start, div_a, div_b, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs: got v=%b q=%h r=%h dz=%b tmo=%b st=%b a=%h b=%h busy=%b expected all 0",
                               rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo, div_start, div_a, div_b, busy);
        end
        req_valid = '0;
        @(negedge clk);
        rst_ni = 1'b1; mptr = 0;
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        logic [N-1:0] gm; int tg, tr, ts, ns; bit ok;
        logic [DW-1:0] a, b, eq, er;
        a = 100; b = 7; eq = a / b; er = a % b;
        dm_lat = 8;
        set_req(0, a, b);
        wait_grant(20, gm, tg, ok);
        checks++; if (!ok || gm !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", gm); end
        @(posedge clk); #1; req_valid = '0;
        wait_rsp(50, tr, ns, ts, ok);
        checks++; if (!ok || tr !== tg + 10) begin errors++; $display("FAIL single_latency: got %0d expected %0d", tr - tg, 10); end
        checks++; if (ns !== 1 || ts !== tg + 1) begin errors++; $display("FAIL single_start: got count=%0d at +%0d expected 1 at +1", ns, ts - tg); end
        checks++; if ({div_a, div_b} !== {a, b}) begin errors++; $display("FAIL single_operands: got %0d/%0d expected %0d/%0d", div_a, div_b, a, b); end
        checks++; if ({rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo} !== {4'b0001, eq, er, 2'b00}) begin
            errors++; $display("FAIL single_rsp: got v=%b q=%0d r=%0d dz=%b tmo=%b expected v=0001 q=%0d r=%0d dz=0 tmo=0", rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo, eq, er);
        end
        handshake(4'b0001);
        @(negedge clk); #1;
        checks++; if ({rsp_valid, busy, rsp_q, rsp_r} !== {4'b0000, 1'b0, eq, er}) begin
            errors++; $display("FAIL single_after_hs: got v=%b busy=%b q=%0d r=%0d expected v=0 busy=0 q=%0d r=%0d", rsp_valid, busy, rsp_q, rsp_r, eq, er);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] gm, em; int tg, tr, ts, ns, eg, prev_tr; bit ok;
        logic [DW-1:0] a, b;
        apply_reset();
        dm_lat = 3;
        for (int i = 0; i < N; i++) set_req(i, 9 + 3 * i, 3);
        rsp_ready = '1;
        prev_tr = -1;
        for (int n = 0; n < 5; n++) begin
            eg = rr_pick(mptr, req_valid);
            em = '0; em[eg] = 1'b1;
            a = req_a[eg*DW +: DW]; b = req_b[eg*DW +: DW];
            wait_grant(20, gm, tg, ok);
            checks++; if (!ok || gm !== em) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, gm, em); end
            if (prev_tr >= 0) begin
                checks++; if (tg !== prev_tr + 1) begin errors++; $display("FAIL rr_gap%0d: got %0d expected 1", n, tg - prev_tr); end
            end
            wait_rsp(30, tr, ns, ts, ok);
            checks++; if (!ok || {rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo} !== {em, a / b, a % b, 2'b00}) begin
                errors++; $display("FAIL rr_rsp%0d: got v=%b q=%0d r=%0d expected v=%b q=%0d r=%0d", n, rsp_valid, rsp_q, rsp_r, em, a / b, a % b);
            end
            prev_tr = tr;
            mptr = (eg + 1) % N;
        end
        req_valid = '0;
        @(posedge clk); #1;
        rsp_ready = '0;
    endtask

    task automatic test_div_zero();
        logic [N-1:0] gm; int tg, tr, ts, ns; bit ok;
        logic [DW-1:0] a, eq;
        a = 32'h1234; eq = '1;
        set_req(2, a, 0);
        wait_grant(20, gm, tg, ok);
        checks++; if (!ok || gm !== 4'b0100) begin errors++; $display("FAIL dz_grant: got %b expected 0100", gm); end
        @(posedge clk); #1; req_valid = '0;
        wait_rsp(10, tr, ns, ts, ok);
        checks++; if (!ok || tr !== tg + 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", tr - tg); end
        checks++; if ({rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo} !== {4'b0100, eq, a, 2'b10}) begin
            errors++; $display("FAIL dz_rsp: got v=%b q=%h r=%h dz=%b tmo=%b expected v=0100 q=%h r=%h dz=1 tmo=0", rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo, eq, a);
        end
        ns = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; if (div_start) ns++; end
        handshake(4'b0100);
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; if (div_start) ns++; end
        checks++; if (ns !== 0) begin errors++; $display("FAIL dz_no_start: got %0d starts expected 0", ns); end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] gm; int tg, tr, ts, ns, th; bit ok;
        logic [DW-1:0] a, b, a0, b0;
        a = $urandom; b = DW'($urandom_range(1, 999));
        a0 = $urandom; b0 = DW'($urandom_range(1, 999));
        dm_lat = 5;
        set_req(1, a, b);
        wait_grant(20, gm, tg, ok);
        checks++; if (!ok || gm !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b expected 0010", gm); end
        @(posedge clk); #1;
        req_valid = '0;
        set_req(0, a0, b0);
        wait_rsp(30, tr, ns, ts, ok);
        checks++; if (!ok || rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_rsp_valid: got %b expected 0010", rsp_valid); end
        rsp_ready = 4'b1101;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            checks++; if ({rsp_valid, rsp_q, rsp_r, req_ready} !== {4'b0010, a / b, a % b, 4'b0000}) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b q=%0d r=%0d rdy=%b expected v=0010 q=%0d r=%0d rdy=0000", i, rsp_valid, rsp_q, rsp_r, req_ready, a / b, a % b);
            end
        end
        rsp_ready = 4'b0010;
        th = cyc_n;
        wait_grant(10, gm, tg, ok);
        rsp_ready = '0;
        checks++; if (!ok || gm !== 4'b0001 || tg !== th + 1) begin
            errors++; $display("FAIL bp_grant0: got %b at +%0d expected 0001 at +1", gm, tg - th);
        end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0000", rsp_valid); end
        @(posedge clk); #1; req_valid = '0;
        wait_rsp(30, tr, ns, ts, ok);
        checks++; if (!ok || {rsp_valid, rsp_q, rsp_r} !== {4'b0001, a0 / b0, a0 % b0}) begin
            errors++; $display("FAIL bp_rsp0: got v=%b q=%0d r=%0d expected v=0001 q=%0d r=%0d", rsp_valid, rsp_q, rsp_r, a0 / b0, a0 % b0);
        end
        handshake(4'b0001);
    endtask

    task automatic test_timeout();
        logic [N-1:0] gm; int tg, tr, ts, ns; bit ok;
        dm_silent = 1'b1;
        set_req(3, $urandom, DW'($urandom_range(1, 50)));
        wait_grant(20, gm, tg, ok);
        checks++; if (!ok || gm !== 4'b1000) begin errors++; $display("FAIL tmo_grant: got %b expected 1000", gm); end
        @(posedge clk); #1; req_valid = '0;
        wait_rsp(TMO + 20, tr, ns, ts, ok);
        checks++; if (!ok || tr !== tg + TMO + 2) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", tr - tg, TMO + 2); end
        checks++; if ({rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo} !== {4'b1000, 32'd0, 32'd0, 2'b01}) begin
            errors++; $display("FAIL tmo_rsp: got v=%b q=%h r=%h dz=%b tmo=%b expected v=1000 q=0 r=0 dz=0 tmo=1", rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo);
        end
        inject_end = 1'b1;
        repeat (3) begin @(negedge clk); #1; end
        checks++; if ({rsp_valid, rsp_q, rsp_r, rsp_tmo} !== {4'b1000, 32'd0, 32'd0, 1'b1}) begin
            errors++; $display("FAIL tmo_late_end: got v=%b q=%h r=%h tmo=%b expected v=1000 q=0 r=0 tmo=1", rsp_valid, rsp_q, rsp_r, rsp_tmo);
        end
        handshake(4'b1000);
        inject_end = 1'b1;
        repeat (3) begin @(negedge clk); #1; end
        checks++; if ({busy, rsp_valid, rsp_tmo} !== {1'b0, 4'b0000, 1'b1}) begin
            errors++; $display("FAIL tmo_idle_end: got busy=%b v=%b tmo=%b expected busy=0 v=0000 tmo=1", busy, rsp_valid, rsp_tmo);
        end
        dm_silent = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        logic [N-1:0] gm; int tg, tr, ts, ns; bit ok;
        dm_lat = 10;
        set_req(1, $urandom, DW'($urandom_range(1, 99)));
        wait_grant(20, gm, tg, ok);
        @(posedge clk); #1; req_valid = '0;
        repeat (4) begin @(negedge clk); #1; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstw_busy_before: got %b expected 1", busy); end
        rst_ni = 1'b0;
        #1;
        checks++; if ({req_ready, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo, div_start, div_a, div_b, busy} !== '0) begin
            errors++; $display("FAIL rstw_outputs: got rdy=%b v=%b q=%h r=%h st=%b a=%h b=%h busy=%b expected all 0",
                               req_ready, rsp_valid, rsp_q, rsp_r, div_start, div_a, div_b, busy);
        end
        repeat (2) @(negedge clk);
        rst_ni = 1'b1; mptr = 0;
        repeat (12) @(negedge clk);
        #1;
        dm_lat = 8;
        set_req(2, 50, 5);
        wait_grant(20, gm, tg, ok);
        checks++; if (!ok || gm !== 4'b0100) begin errors++; $display("FAIL rstw_grant: got %b expected 0100", gm); end
        @(posedge clk); #1; req_valid = '0;
        wait_rsp(30, tr, ns, ts, ok);
        checks++; if (!ok || tr !== tg + 10 || {rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo} !== {4'b0100, 32'd10, 32'd0, 2'b00}) begin
            errors++; $display("FAIL rstw_rsp: got lat=%0d v=%b q=%0d r=%0d expected lat=10 v=0100 q=10 r=0", tr - tg, rsp_valid, rsp_q, rsp_r);
        end
        handshake(4'b0100);
    endtask

    task automatic test_random();
        logic [N-1:0] gm, em, mask; int tg, tr, ts, ns, eg, elat; bit ok;
        logic [DW-1:0] ea, eb, eq, er, a, b;
        bit edz;
        apply_reset();
        for (int it = 0; it < 40; it++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                a = $urandom;
                case ($urandom_range(0, 5))
                    0:       b = '0;
                    1:       b = $urandom;
                    default: b = DW'($urandom_range(1, 5000));
                endcase
                req_a[i*DW +: DW] = a;
                req_b[i*DW +: DW] = b;
            end
            dm_lat = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) begin
                div_ready = 1'b0;
                req_valid = mask;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk); #1;
                    checks++; if ({req_ready, busy} !== {4'b0000, 1'b0}) begin
                        errors++; $display("FAIL rnd_div_busy%0d: got rdy=%b busy=%b expected 0000 0", it, req_ready, busy);
                    end
                end
                div_ready = 1'b1;
            end
            req_valid = mask;
            eg = rr_pick(mptr, mask);
            em = '0; em[eg] = 1'b1;
            ea = req_a[eg*DW +: DW]; eb = req_b[eg*DW +: DW];
            edz = (eb == 0);
            eq = edz ? '1 : ea / eb;
            er = edz ? ea : ea % eb;
            elat = edz ? 1 : dm_lat + 2;
            wait_grant(10, gm, tg, ok);
            checks++; if (!ok || gm !== em) begin errors++; $display("FAIL rnd_grant%0d: got %b expected %b", it, gm, em); end
            @(posedge clk); #1;
            req_valid = '0;
            for (int i = 0; i < N; i++) begin
                req_a[i*DW +: DW] = $urandom;
                req_b[i*DW +: DW] = $urandom;
            end
            wait_rsp(TMO + 20, tr, ns, ts, ok);
            checks++; if (!ok || tr !== tg + elat) begin errors++; $display("FAIL rnd_latency%0d: got %0d expected %0d", it, tr - tg, elat); end
            checks++; if ({rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo} !== {em, eq, er, edz, 1'b0}) begin
                errors++; $display("FAIL rnd_rsp%0d: got v=%b q=%h r=%h dz=%b tmo=%b expected v=%b q=%h r=%h dz=%b tmo=0",
                                   it, rsp_valid, rsp_q, rsp_r, rsp_dz, rsp_tmo, em, eq, er, edz);
            end
            repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
            handshake(em);
            mptr = (eg + 1) % N;
        end
    endtask

    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_div_zero();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/net_div_sched.md
Name: net_div_sched

Overview:
- Round-robin scheduler that shares one pipelined integer divider (start/ready/end interface, fixed latency) among N_REQ requesters in the network core.
- Accepts one division request at a time and issues it to the divider.
- Waits for the result, with a timeout guard, and returns quotient/remainder to the originating requester over a valid/ready response channel.
- Handles divide-by-zero locally, without occupying the divider.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 32, operand/result width.
- TMO, 64, max cycles waited for div_end_i after issue before declaring timeout (must exceed divider latency).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- req_valid_i  in  N_REQ  per-requester request valid.
- req_ready_o  out  N_REQ  one-hot accept pulse.
- req_a_i  in  N_REQ*DW  dividends, requester i at bits [i*DW +: DW].
- req_b_i  in  N_REQ*DW  divisors, same packing.
- rsp_valid_o  out  N_REQ  one-hot response valid.
- rsp_ready_i  in  N_REQ  per-requester response ready.
- rsp_q_o  out  DW  quotient, shared bus, meaningful for the requester whose rsp_valid_o is high.
- rsp_r_o  out  DW  remainder.
- rsp_dz_o  out  1  divide-by-zero flag.
- rsp_tmo_o  out  1  timeout flag.
- div_start_o  out  1  one-cycle start to divider.
- div_a_o  out  DW  registered dividend to divider.
- div_b_o  out  DW  registered divisor to divider.
- div_ready_i  in  1  divider idle.
- div_end_i  in  1  divider result-valid pulse.
- div_q_i  in  DW  divider quotient.
- div_r_i  in  DW  divider remainder.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: clk_i is the clock; rst_ni is the reset, asynchronous and active-low. It forces:
  - FSM to IDLE and rr pointer to 0.
  - All outputs to 0: req_ready_o, rsp_valid_o, rsp_q_o, rsp_r_o, rsp_dz_o, rsp_tmo_o, div_start_o, div_a_o, div_b_o, busy_o.
  - Owner id and timeout counter to 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid_i is high and div_ready_i=1, grant the first valid requester scanning ptr, ptr+1, … modulo N_REQ.
  - In that same cycle, drive req_ready_o[g]=1 combinationally for exactly one cycle.
  - Latch A, B and owner id g.
  - If B==0: go to RESP with q=all-ones, r=A, dz=1. No divider start.
  - Else: go to ISSUE.
  - If div_ready_i=0, grant nothing and remain in IDLE.
- ISSUE:
  - div_start_o=1 for exactly one cycle, with div_a_o/div_b_o holding the latched operands.
  - Clear the timeout counter and go to WAIT.
  - div_a_o/div_b_o stay stable until the next grant.
- WAIT:
  - Increment the counter each cycle.
  - On div_end_i=1: capture div_q_i/div_r_i, set dz=0, tmo=0, go to RESP.
  - If the counter reaches TMO-1 without div_end_i: set q=0, r=0, tmo=1, go to RESP.
  - div_end_i outside WAIT is ignored.
- RESP:
  - rsp_valid_o[owner]=1 with rsp_q_o/rsp_r_o/rsp_dz_o/rsp_tmo_o stable.
  - On rsp_ready_i[owner]=1: drop valid next cycle, set ptr=owner+1 mod N_REQ, go to IDLE.
  - rsp_ready_i of non-owners is ignored.
- Latency:
  - Accept cycle T → div_start_o at T+1 → div_end_i at T+1+L (L = divider latency) → rsp_valid_o at T+2+L.
  - Zero-divisor response valid at T+1.
- Throughput: one outstanding operation; the next grant occurs earliest in the cycle after response acceptance.
- Request values are sampled only in the accept cycle; later changes to req_a_i/req_b_i have no effect.
- A requester dropping req_valid_i before grant simply loses arbitration; no state change.
- Fairness: a requester holding valid continuously is granted within N_REQ grants.
- Response registers hold their last value after the handshake, until overwritten by the next capture.
- Reset mid-operation aborts everything. Any divider operation still in flight completes unobserved, because div_end_i is ignored outside WAIT.

Test Plan:
- Single req: req0 A=100, B=7, divider latency 8 → req_ready_o[0] pulse, one div_start_o, rsp_valid_o[0] 10 cycles after accept with q=14, r=2, dz=0, tmo=0.
- Round-robin: all 4 requests held valid with B=3 and A=9,12,15,18 respectively, rsp_ready_i tied high → grant order 0,1,2,3,0; each response routed to the correct rsp_valid_o bit with q=3,4,5,6.
- Divide by zero: req2 A=0x1234, B=0 → rsp_valid_o[2] one cycle after accept, q=0xFFFFFFFF, r=0x1234, dz=1, div_start_o never asserted.
- Backpressure: rsp_ready_i[1] low for 20 cycles → rsp_valid_o[1] and data held stable; req0 valid meanwhile gets no grant until 1 cycle after the handshake.
- Timeout: divider model never asserts div_end_i, TMO=64 → rsp_tmo_o=1, q=0, r=0 after 64 WAIT cycles; a late div_end_i is ignored.
- Reset mid-WAIT: pull rst_ni low asynchronously → all outputs 0 immediately; after release, a new request for 50/5 returns q=10, r=0.
